// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, addresses the instruction memory and
// registers each fetched word into a one-entry valid/ready stage feeding decode.
module inst_fetch_ctrl #(
  parameter int          MEM_BYTES = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_en,
  output logic [31:0]      imem_pc,
  input  logic [31:0]      imem_instr,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic             halted,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] redir_pc_al;
  logic [31:0] pc_inc;
  logic        redir_oob;
  logic        pc_inc_oob;
  logic        handshake;
  logic        stage_free;
  logic        capture;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign imem_pc     = pc_q;
  assign redir_pc_al = {redirect_pc[31:2], 2'b00};
  // Compare in 33 bits so a target near the top of the address space cannot wrap.
  assign redir_oob   = {1'b0, redir_pc_al} >= MEM_LIMIT;
  assign pc_inc      = pc_q + 32'd4;
  assign pc_inc_oob  = ({1'b0, pc_q} + 33'd4) >= MEM_LIMIT;
  assign handshake   = out_valid & out_ready;
  assign stage_free  = ~out_valid | out_ready;
  assign capture     = (state_q == FETCH) & fetch_en & stage_free;
  assign halted      = (state_q == HALT);

  // Fetch / output stage: PC update, instruction capture, handshake accounting
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      out_valid    <= 1'b0;
      out_instr    <= 32'h0;
      out_pc       <= 32'h0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else if (redirect_valid) begin
      // Flush wins over any handshake in the same cycle, so nothing is counted.
      pc_q         <= redir_pc_al;
      out_valid    <= 1'b0;
      misalign_err <= |redirect_pc[1:0];
      if (redir_oob)     state_q <= HALT;
      else if (fetch_en) state_q <= FETCH;
      else               state_q <= IDLE;
    end else begin
      misalign_err <= 1'b0;
      if (handshake) fetch_count <= sat_inc(fetch_count);
      if (capture) begin
        out_instr <= imem_instr;
        out_pc    <= pc_q;
        out_valid <= 1'b1;
        pc_q      <= pc_inc;
        if (pc_inc_oob) state_q <= HALT;
      end else begin
        if (handshake) out_valid <= 1'b0;
        case (state_q)
          IDLE:    if (fetch_en)  state_q <= FETCH;
          FETCH:   if (!fetch_en) state_q <= IDLE;
          default: state_q <= state_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_inst_fetch_ctrl;

  localparam int          MEM_BYTES = 32;
  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam int          CNT_W     = 8;
  localparam int          NWORDS    = MEM_BYTES / 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             fetch_en = 1'b0;
  logic [31:0]      imem_pc;
  logic [31:0]      imem_instr;
  logic             redirect_valid = 1'b0;
  logic [31:0]      redirect_pc = 32'h0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic             halted;
  logic             misalign_err;
  logic [CNT_W-1:0] fetch_count;

  logic [31:0] mem [NWORDS];

  int checks = 0;
  int errors = 0;

  // Reference model: the program counter, the contents of the output slot,
  // and whether the fetcher is stopped, running, or parked at end of memory.
  int          m_mode;   // 0 stopped, 1 running, 2 parked
  logic [31:0] m_pc;
  bit          m_slot_full;
  logic [31:0] m_slot_instr;
  logic [31:0] m_slot_pc;
  bit          m_mis;
  int          m_accepted;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_pc[4:2]];

  inst_fetch_ctrl #(
    .MEM_BYTES(MEM_BYTES),
    .RESET_PC (RESET_PC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .imem_pc       (imem_pc),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .halted        (halted),
    .misalign_err  (misalign_err),
    .fetch_count   (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit fe, input bit rv,
                            input logic [31:0] rp, input bit rdy);
    logic [31:0] tgt;
    bit          taken;
    if (rst) begin
      m_mode = 0; m_pc = RESET_PC; m_slot_full = 0; m_slot_instr = 0;
      m_slot_pc = 0; m_mis = 0; m_accepted = 0;
    end else if (rv) begin
      tgt         = rp & 32'hFFFF_FFFC;
      m_pc        = tgt;
      m_slot_full = 0;
      m_mis       = (rp % 4) != 0;
      m_mode      = (tgt >= MEM_BYTES) ? 2 : (fe ? 1 : 0);
    end else begin
      m_mis = 0;
      taken = m_slot_full && rdy;
      if (taken) m_accepted++;
      if (m_mode == 1 && fe && (!m_slot_full || rdy)) begin
        m_slot_instr = mem[(m_pc / 4) % NWORDS];
        m_slot_pc    = m_pc;
        m_slot_full  = 1;
        m_pc         = m_pc + 4;
        if (m_pc >= MEM_BYTES) m_mode = 2;
      end else begin
        if (taken) m_slot_full = 0;
        if (m_mode != 2) m_mode = fe ? 1 : 0;
      end
    end
  endtask

  task automatic compare_all();
    int sat;
    sat = (m_accepted > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : m_accepted;
    chk("out_valid", 32'(out_valid), 32'(m_slot_full));
    if (m_slot_full) begin
      chk("out_pc", out_pc, m_slot_pc);
      chk("out_instr", out_instr, m_slot_instr);
    end
    chk("imem_pc", imem_pc, m_pc);
    chk("halted", 32'(halted), 32'(m_mode == 2));
    chk("misalign_err", 32'(misalign_err), 32'(m_mis));
    chk("fetch_count", 32'(fetch_count), 32'(sat));
  endtask

  task automatic step(input bit rst, input bit fe, input bit rv,
                      input logic [31:0] rp, input bit rdy);
    reset = rst; fetch_en = fe; redirect_valid = rv; redirect_pc = rp; out_ready = rdy;
    @(posedge clk);
    model_edge(rst, fe, rv, rp, rdy);
    #1;
    compare_all();
  endtask

  initial begin
    mem[0] = 32'h0094_0333;
    for (int i = 1; i < NWORDS; i++) mem[i] = 32'h1000_0000 + 32'(i * 32'h0101_0101);

    // 1: straight-line run to end of memory
    step(1, 0, 0, 0, 0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_imem_pc", imem_pc, RESET_PC);
    chk("reset_count", 32'(fetch_count), 32'h0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    chk("first_instr", out_instr, 32'h0094_0333);
    chk("first_pc", out_pc, 32'h0);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 1);
    chk("t1_halted", 32'(halted), 32'h1);
    chk("t1_count", 32'(fetch_count), 32'd8);

    // 2: backpressure holds the stage and the PC
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1);
    chk("t2_out_pc_8", out_pc, 32'd8);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    chk("t2_hold_pc", out_pc, 32'd8);
    chk("t2_hold_imem", imem_pc, 32'd12);
    step(0, 1, 0, 0, 1);
    chk("t2_resume_12", out_pc, 32'd12);
    step(0, 1, 0, 0, 1);
    chk("t2_resume_16", out_pc, 32'd16);

    // 3: redirect flushes a valid instruction without counting it
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);
    chk("t3_out_pc_4", out_pc, 32'd4);
    step(0, 1, 1, 32'h14, 1);
    chk("t3_flush_valid", 32'(out_valid), 32'h0);
    chk("t3_flush_count", 32'(fetch_count), 32'd1);
    step(0, 1, 0, 0, 1);
    chk("t3_target_pc", out_pc, 32'h14);

    // 4: misaligned redirect, then redirect beyond memory
    step(0, 1, 1, 32'h0A, 1);
    chk("t4_misalign", 32'(misalign_err), 32'h1);
    step(0, 1, 0, 0, 1);
    chk("t4_misalign_clr", 32'(misalign_err), 32'h0);
    chk("t4_pc_8", out_pc, 32'h08);
    step(0, 1, 1, 32'h40, 1);
    chk("t4_oob_halt", 32'(halted), 32'h1);
    step(0, 1, 0, 0, 1);
    chk("t4_no_capture", 32'(out_valid), 32'h0);

    // 5: stop mid-stream, drain, restart without skip or duplicate
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t5_held_pc", out_pc, 32'd4);
    step(0, 0, 0, 0, 1);
    chk("t5_drained", 32'(out_valid), 32'h0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    chk("t5_restart_pc", out_pc, 32'd8);

    // 6: reset mid-stream
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("t6_valid", 32'(out_valid), 32'h0);
    chk("t6_imem_pc", imem_pc, RESET_PC);
    chk("t6_out_pc", out_pc, 32'h0);

    // Counter saturation: repeat whole-memory runs until the count pegs
    for (int r = 0; r < 34; r++) begin
      step(0, 1, 1, 32'h0, 1);
      for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 1);
    end
    chk("sat_count", 32'(fetch_count), 32'd255);

    // Randomized traffic
    for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 11) == 0),
           32'($urandom_range(0, 40)),
           ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
